// File: rtl/priority_arbiter.sv
// Request arbiter with fixed-priority or round-robin selection, lock hold,
// and a registered valid/ready grant that issues back-to-back without bubbles.
module priority_arbiter #(
  parameter int unsigned N_REQ   = 8,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             lock,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic [IW-1:0]    gnt_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    ptr_adv;
  logic [IW-1:0]    start;
  logic [IW-1:0]    sel;
  logic             valid_d;
  logic [IW-1:0]    idx_d;
  logic [N_REQ-1:0] onehot_d;

  // First set request at or after s, wrapping back to index 0.
  function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [IW-1:0] s);
    logic [IW-1:0] res;
    logic          found;
    int unsigned   j;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(s) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && r[IW'(j)]) begin
        found = 1'b1;
        res   = IW'(j);
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = gnt_valid;
    idx_d    = gnt_idx;
    onehot_d = gnt_onehot;
    ptr_adv  = '0;

    // The served index lands at the tail of the search order, so it only
    // wins a back-to-back selection when nothing else is requesting.
    if (RR_MODE != 0) begin
      ptr_adv = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
    start = (state_q == GRANT) ? ptr_adv : ptr_q;
    sel   = pick(req, start);

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = sel;
          onehot_d = N_REQ'(1) << sel;
        end
      end
      GRANT: begin
        if (gnt_ready && !(lock && req[gnt_idx])) begin
          ptr_d = ptr_adv;
          if (|req) begin
            idx_d    = sel;
            onehot_d = N_REQ'(1) << sel;
          end else begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            idx_d    = '0;
            onehot_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_valid  <= valid_d;
      gnt_idx    <= idx_d;
      gnt_onehot <= onehot_d;
    end
  end

endmodule
